// File: rtl/fifo_type_2_pkg.sv
// fifo_type_2_pkg: shared types, read-mode constants and width helper for fifo_type_2_sync_mc.
package fifo_type_2_pkg;
  localparam string FWFT_TRUE = "true";
  localparam string FWFT_FALSE = "false";
  localparam int DEF_ADDRESS_WIDTH = 3;
  localparam int DEF_NUM_CHANNELS = 4;
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  typedef logic [clog2_min1(DEF_NUM_CHANNELS)-1:0] ch_idx_t;
  typedef logic [DEF_ADDRESS_WIDTH:0] occ_t;
endpackage

// File: rtl/fifo_type_2_channel_ctrl.sv
// fifo_type_2_channel_ctrl: one channel's pointers, occupancy counter and status flag decode.
module fifo_type_2_channel_ctrl
  import fifo_type_2_pkg::*;
#(
  parameter int AddressWidth = 3,
  parameter int AlmostFullThreshold = 7,
  parameter int AlmostEmptyThreshold = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    rd_en,
  output logic [AddressWidth-1:0] wptr,
  output logic [AddressWidth-1:0] rptr,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty
);
  localparam logic [AddressWidth:0] DepthV = {1'b1, {AddressWidth{1'b0}}};
  localparam logic [AddressWidth:0] AfTh = (AddressWidth+1)'(AlmostFullThreshold);
  localparam logic [AddressWidth:0] AeTh = (AddressWidth+1)'(AlmostEmptyThreshold);
  logic [AddressWidth:0] occ;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      if (wr_en != rd_en) occ <= wr_en ? occ + 1'b1 : occ - 1'b1;
    end
  end
  always_comb begin
    full         = occ == DepthV;
    empty        = occ == '0;
    almost_full  = occ >= AfTh;
    almost_empty = occ <= AeTh;
  end
endmodule

// File: rtl/fifo_type_2_sync_mc.sv
// fifo_type_2_sync_mc: single-clock multi-channel FIFO with shared storage, FWFT or registered read.
// Optional sticky overflow/underflow outputs when FIFO_TYPE_2_ERR_EN is defined.
module fifo_type_2_sync_mc
  import fifo_type_2_pkg::*;
#(
  parameter int    DataWidth = 32,
  parameter int    AddressWidth = 3,
  parameter int    NumChannels = 4,
  parameter string FirstWordFallThrough = FWFT_TRUE,
  parameter int    AlmostFullThreshold = 2**AddressWidth - 1,
  parameter int    AlmostEmptyThreshold = 1,
  localparam int   ChW = clog2_min1(NumChannels)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_req,
  input  logic [ChW-1:0]         wr_channel,
  input  logic [DataWidth-1:0]   wr_data,
  output logic [NumChannels-1:0] wr_full,
  output logic [NumChannels-1:0] wr_almost_full,
  input  logic                   rd_req,
  input  logic [ChW-1:0]         rd_channel,
  output logic [DataWidth-1:0]   rd_data,
  output logic                   rd_valid,
  output logic [NumChannels-1:0] rd_empty,
  output logic [NumChannels-1:0] rd_almost_empty
`ifdef FIFO_TYPE_2_ERR_EN
  ,
  output logic                   err_overflow,
  output logic                   err_underflow
`endif
);
  localparam int Depth = 2**AddressWidth;
  localparam bit Fwft = FirstWordFallThrough == FWFT_TRUE;
  logic [DataWidth-1:0] mem [NumChannels*Depth];
  logic [AddressWidth-1:0] wptr [NumChannels];
  logic [AddressWidth-1:0] rptr [NumChannels];
  logic [NumChannels-1:0] wr_sel, rd_sel;
  logic wr_acc, rd_avail, rd_acc;
  logic [DataWidth-1:0] head;
  // Fullness/emptiness come from the pre-edge counters, so a same-cycle pop never frees room for a write.
  always_comb begin
    wr_acc   = wr_req && (int'(wr_channel) < NumChannels) && !wr_full[wr_channel];
    rd_avail = (int'(rd_channel) < NumChannels) && !rd_empty[rd_channel];
    rd_acc   = rd_req && rd_avail;
    wr_sel   = wr_acc ? NumChannels'(1) << wr_channel : '0;
    rd_sel   = rd_acc ? NumChannels'(1) << rd_channel : '0;
    head     = mem[{rd_channel, rptr[rd_channel]}];
  end
  for (genvar i = 0; i < NumChannels; i++) begin : g_ch
    fifo_type_2_channel_ctrl #(
      .AddressWidth(AddressWidth),
      .AlmostFullThreshold(AlmostFullThreshold),
      .AlmostEmptyThreshold(AlmostEmptyThreshold)
    ) u_ctrl (
      .clk(clk),
      .rst(rst),
      .wr_en(wr_sel[i]),
      .rd_en(rd_sel[i]),
      .wptr(wptr[i]),
      .rptr(rptr[i]),
      .full(wr_full[i]),
      .empty(rd_empty[i]),
      .almost_full(wr_almost_full[i]),
      .almost_empty(rd_almost_empty[i])
    );
  end
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[{wr_channel, wptr[wr_channel]}] <= wr_data;
  end
  if (Fwft) begin : g_fwft
    always_comb begin
      rd_data  = head;
      rd_valid = rd_avail;
    end
  end else begin : g_std
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= head;
      end
    end
  end
`ifdef FIFO_TYPE_2_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (wr_req && !wr_acc) err_overflow <= 1'b1;
      if (rd_req && !rd_acc) err_underflow <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_type_2_sync_mc.sv
// tb_fifo_type_2_sync_mc: directed table-driven bench driving an FWFT and a standard-mode instance in lockstep.
module tb_fifo_type_2_sync_mc;
  import fifo_type_2_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_req = 1'b0, rd_req = 1'b0;
  ch_idx_t wr_channel = '0, rd_channel = '0;
  logic [31:0] wr_data = '0;
  logic [3:0] f_full, f_af, f_empty, f_ae, s_full, s_af, s_empty, s_ae;
  logic [31:0] f_data, s_data;
  logic f_valid, s_valid;
`ifdef FIFO_TYPE_2_ERR_EN
  logic f_ovf, f_unf, s_ovf, s_unf;
`endif
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  fifo_type_2_sync_mc #(.FirstWordFallThrough(FWFT_TRUE), .AlmostFullThreshold(6), .AlmostEmptyThreshold(1)) dut_f (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_channel(wr_channel), .wr_data(wr_data),
    .wr_full(f_full), .wr_almost_full(f_af), .rd_req(rd_req), .rd_channel(rd_channel),
    .rd_data(f_data), .rd_valid(f_valid), .rd_empty(f_empty), .rd_almost_empty(f_ae)
`ifdef FIFO_TYPE_2_ERR_EN
    , .err_overflow(f_ovf), .err_underflow(f_unf)
`endif
  );
  fifo_type_2_sync_mc #(.FirstWordFallThrough(FWFT_FALSE), .AlmostFullThreshold(6), .AlmostEmptyThreshold(1)) dut_s (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_channel(wr_channel), .wr_data(wr_data),
    .wr_full(s_full), .wr_almost_full(s_af), .rd_req(rd_req), .rd_channel(rd_channel),
    .rd_data(s_data), .rd_valid(s_valid), .rd_empty(s_empty), .rd_almost_empty(s_ae)
`ifdef FIFO_TYPE_2_ERR_EN
    , .err_overflow(s_ovf), .err_underflow(s_unf)
`endif
  );
  typedef struct {
    logic w; ch_idx_t wc; logic [31:0] wd; logic r; ch_idx_t rc;
    logic [3:0] em; logic [3:0] ae; logic fv; logic [31:0] fd; logic sv; logic [31:0] sd;
  } vec_t;
  vec_t tbl [13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic drive(input logic w, input ch_idx_t wc, input logic [31:0] wd, input logic r, input ch_idx_t rc);
    wr_req = w; wr_channel = wc; wr_data = wd; rd_req = r; rd_channel = rc;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic step(input logic w, input ch_idx_t wc, input logic [31:0] wd, input logic r, input ch_idx_t rc);
    drive(w, wc, wd, r, rc);
    tick();
  endtask
  initial begin
    tbl[0]  = '{1'b1, 2'd2, 32'hA,  1'b0, 2'd2, 4'b1011, 4'hF,    1'b1, 32'hA,  1'b0, 32'h0};
    tbl[1]  = '{1'b0, 2'd2, 32'h0,  1'b1, 2'd2, 4'hF,    4'hF,    1'b0, 32'h0,  1'b1, 32'hA};
    tbl[2]  = '{1'b0, 2'd2, 32'h0,  1'b0, 2'd2, 4'hF,    4'hF,    1'b0, 32'h0,  1'b0, 32'hA};
    tbl[3]  = '{1'b1, 2'd3, 32'h30, 1'b1, 2'd3, 4'b0111, 4'hF,    1'b1, 32'h30, 1'b0, 32'hA};
    tbl[4]  = '{1'b1, 2'd0, 32'h00, 1'b1, 2'd3, 4'b1110, 4'hF,    1'b0, 32'h0,  1'b1, 32'h30};
    tbl[5]  = '{1'b1, 2'd3, 32'h31, 1'b1, 2'd3, 4'b0110, 4'hF,    1'b1, 32'h31, 1'b0, 32'h30};
    tbl[6]  = '{1'b1, 2'd3, 32'h32, 1'b1, 2'd3, 4'b0110, 4'hF,    1'b1, 32'h32, 1'b1, 32'h31};
    tbl[7]  = '{1'b1, 2'd0, 32'h01, 1'b1, 2'd3, 4'b1110, 4'b1110, 1'b0, 32'h0,  1'b1, 32'h32};
    tbl[8]  = '{1'b1, 2'd3, 32'h33, 1'b0, 2'd0, 4'b0110, 4'b1110, 1'b1, 32'h00, 1'b0, 32'h32};
    tbl[9]  = '{1'b1, 2'd3, 32'h34, 1'b1, 2'd3, 4'b0110, 4'b1110, 1'b1, 32'h34, 1'b1, 32'h33};
    tbl[10] = '{1'b0, 2'd0, 32'h0,  1'b1, 2'd0, 4'b0110, 4'hF,    1'b1, 32'h01, 1'b1, 32'h00};
    tbl[11] = '{1'b0, 2'd0, 32'h0,  1'b1, 2'd0, 4'b0111, 4'hF,    1'b0, 32'h0,  1'b1, 32'h01};
    tbl[12] = '{1'b0, 2'd0, 32'h0,  1'b1, 2'd3, 4'hF,    4'hF,    1'b0, 32'h0,  1'b1, 32'h34};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_empty", f_empty, 4'hF);
    chk("reset_full", f_full, 4'h0);
    chk("reset_af", f_af, 4'h0);
    chk("reset_ae", f_ae, 4'hF);
    chk("reset_fwft_valid", f_valid, 1'b0);
    chk("reset_std_valid", s_valid, 1'b0);
    chk("reset_std_data", s_data, 32'h0);
    chk("reset_std_empty", s_empty, 4'hF);
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].w, tbl[i].wc, tbl[i].wd, tbl[i].r, tbl[i].rc);
      chk($sformatf("vec%0d_empty", i), f_empty, tbl[i].em);
      chk($sformatf("vec%0d_full", i), f_full, 4'h0);
      chk($sformatf("vec%0d_af", i), f_af, 4'h0);
      chk($sformatf("vec%0d_ae", i), f_ae, tbl[i].ae);
      chk($sformatf("vec%0d_fwft_valid", i), f_valid, tbl[i].fv);
      if (tbl[i].fv) chk($sformatf("vec%0d_fwft_data", i), f_data, tbl[i].fd);
      chk($sformatf("vec%0d_std_valid", i), s_valid, tbl[i].sv);
      chk($sformatf("vec%0d_std_data", i), s_data, tbl[i].sd);
      chk($sformatf("vec%0d_std_empty", i), s_empty, tbl[i].em);
    end
`ifdef FIFO_TYPE_2_ERR_EN
    chk("err_underflow_set", f_unf, 1'b1);
    chk("err_overflow_clear", f_ovf, 1'b0);
`endif
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'd1, 32'hAAAA0000 + i, 1'b0, 2'd1);
      chk($sformatf("fill%0d_full", i), f_full, (i == 7) ? 4'b0010 : 4'h0);
      chk($sformatf("fill%0d_af", i), f_af, (i >= 5) ? 4'b0010 : 4'h0);
      chk($sformatf("fill%0d_ae", i), f_ae, (i == 0) ? 4'hF : 4'b1101);
      chk($sformatf("fill%0d_head", i), f_data, 32'hAAAA0000);
    end
    step(1'b1, 2'd1, 32'hDEADBEEF, 1'b0, 2'd1);
    chk("overfill_full", f_full, 4'b0010);
    chk("overfill_others_empty", f_empty, 4'b1101);
`ifdef FIFO_TYPE_2_ERR_EN
    chk("err_overflow_set", f_ovf, 1'b1);
`endif
    // First pop also carries a write into the still-full channel; that write must be dropped.
    for (int i = 0; i < 8; i++) begin
      drive(i == 0, 2'd1, 32'hDEADBEEF, 1'b1, 2'd1);
      #1;
      chk($sformatf("drain%0d_fwft_data", i), f_data, 32'hAAAA0000 + i);
      chk($sformatf("drain%0d_fwft_valid", i), f_valid, 1'b1);
      tick();
      chk($sformatf("drain%0d_std_data", i), s_data, 32'hAAAA0000 + i);
      chk($sformatf("drain%0d_std_valid", i), s_valid, 1'b1);
      chk($sformatf("drain%0d_full", i), f_full, 4'h0);
      chk($sformatf("drain%0d_af", i), f_af, (i <= 1) ? 4'b0010 : 4'h0);
      chk($sformatf("drain%0d_ae", i), f_ae, (i >= 6) ? 4'hF : 4'b1101);
    end
    step(1'b0, 2'd0, 32'h0, 1'b0, 2'd1);
    chk("drained_empty", f_empty, 4'hF);
    chk("drained_std_valid", s_valid, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 32'h500 + i, 1'b0, 2'd0);
    chk("halffill_empty", f_empty, 4'b1110);
    rst = 1'b1;
    step(1'b1, 2'd0, 32'h55, 1'b1, 2'd0);
    rst = 1'b0;
    chk("midrst_empty", f_empty, 4'hF);
    chk("midrst_full", f_full, 4'h0);
    chk("midrst_af", f_af, 4'h0);
    chk("midrst_ae", f_ae, 4'hF);
    chk("midrst_fwft_valid", f_valid, 1'b0);
    chk("midrst_std_valid", s_valid, 1'b0);
    chk("midrst_std_data", s_data, 32'h0);
`ifdef FIFO_TYPE_2_ERR_EN
    chk("midrst_err_overflow", f_ovf, 1'b0);
    chk("midrst_err_underflow", f_unf, 1'b0);
`endif
    step(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
    chk("postrst_fwft_valid", f_valid, 1'b0);
    chk("postrst_std_valid", s_valid, 1'b0);
    chk("postrst_empty", f_empty, 4'hF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
